// File: rtl/sirv_expl_icb2axi.sv
// sirv_expl_icb2axi: single-outstanding ICB to AXI bridge, one single-beat AXI transfer per ICB command.
// Define SIRV_EXPL_ICB2AXI_RSP_BYPASS_EN to drive the ICB response straight from the R/B channel.
module sirv_expl_icb2axi #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic            icb_cmd_read,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic [DW-1:0]   icb_rsp_rdata,
    output logic            icb_rsp_err,
    output logic            axi_arvalid,
    input  logic            axi_arready,
    output logic [AW-1:0]   axi_araddr,
    output logic [3:0]      axi_arcache,
    output logic [2:0]      axi_arprot,
    output logic [1:0]      axi_arlock,
    output logic [1:0]      axi_arburst,
    output logic [3:0]      axi_arlen,
    output logic [2:0]      axi_arsize,
    output logic            axi_awvalid,
    input  logic            axi_awready,
    output logic [AW-1:0]   axi_awaddr,
    output logic [3:0]      axi_awcache,
    output logic [2:0]      axi_awprot,
    output logic [1:0]      axi_awlock,
    output logic [1:0]      axi_awburst,
    output logic [3:0]      axi_awlen,
    output logic [2:0]      axi_awsize,
    output logic            axi_wvalid,
    input  logic            axi_wready,
    output logic [DW-1:0]   axi_wdata,
    output logic [DW/8-1:0] axi_wstrb,
    output logic            axi_wlast,
    input  logic            axi_rvalid,
    output logic            axi_rready,
    input  logic [DW-1:0]   axi_rdata,
    input  logic [1:0]      axi_rresp,
    input  logic            axi_rlast,
    input  logic            axi_bvalid,
    output logic            axi_bready,
    input  logic [1:0]      axi_bresp
);
    localparam logic [2:0] AXI_SIZE = (DW == 64) ? 3'd3 : 3'd2;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wmask_q;
    logic            ar_done, aw_done, w_done;
    logic            cmd_hs, ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic            aw_ok, w_ok, wr_fin;
    logic            unused_ok;

    assign unused_ok = &{1'b0, axi_rlast, axi_rresp[0], axi_bresp[0]};

    assign icb_cmd_ready = state_q == IDLE;
    assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;

    assign axi_arvalid = (state_q == RD) & ~ar_done;
    assign axi_awvalid = (state_q == WR) & ~aw_done;
    assign axi_wvalid  = (state_q == WR) & ~w_done;

    assign ar_hs = axi_arvalid & axi_arready;
    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid & axi_wready;
    assign r_hs  = axi_rvalid & axi_rready;
    assign b_hs  = axi_bvalid & axi_bready;
    assign aw_ok = aw_done | aw_hs;
    assign w_ok  = w_done | w_hs;

    assign axi_araddr  = addr_q;
    assign axi_arcache = 4'd0;
    assign axi_arprot  = 3'd0;
    assign axi_arlock  = 2'd0;
    assign axi_arburst = 2'b01;
    assign axi_arlen   = 4'd0;
    assign axi_arsize  = AXI_SIZE;
    assign axi_awaddr  = addr_q;
    assign axi_awcache = 4'd0;
    assign axi_awprot  = 3'd0;
    assign axi_awlock  = 2'd0;
    assign axi_awburst = 2'b01;
    assign axi_awlen   = 4'd0;
    assign axi_awsize  = AXI_SIZE;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wmask_q;
    assign axi_wlast   = 1'b1;

`ifdef SIRV_EXPL_ICB2AXI_RSP_BYPASS_EN
    localparam state_t FIN = IDLE;

    // B is only accepted once the ICB side can take the response in the same cycle
    assign axi_rready    = (state_q == RD) & icb_rsp_ready;
    assign axi_bready    = (state_q == WR) & aw_ok & w_ok & icb_rsp_ready;
    assign icb_rsp_valid = (state_q == RD) ? axi_rvalid : (state_q == WR) & aw_ok & w_ok & axi_bvalid;
    assign icb_rsp_rdata = (state_q == RD) ? axi_rdata : '0;
    assign icb_rsp_err   = (state_q == RD) ? axi_rresp[1] : (state_q == WR) & axi_bresp[1];
    assign wr_fin        = b_hs;
`else
    localparam state_t FIN = RSP;

    logic          b_done, b_err_q, rsp_err_q;
    logic [DW-1:0] rsp_rdata_q;

    assign axi_rready    = state_q == RD;
    assign axi_bready    = state_q == WR;
    assign icb_rsp_valid = state_q == RSP;
    assign icb_rsp_rdata = rsp_rdata_q;
    assign icb_rsp_err   = rsp_err_q;
    assign wr_fin        = (state_q == WR) & aw_ok & w_ok & (b_done | b_hs);

    // an early B (before AW/W finish) is remembered together with its error bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_done      <= 1'b0;
            b_err_q     <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            b_done  <= (state_d == IDLE) ? 1'b0 : b_done | b_hs;
            b_err_q <= (state_d == IDLE) ? 1'b0 : b_hs ? axi_bresp[1] : b_err_q;
            if (state_q == RD && r_hs) begin
                rsp_rdata_q <= axi_rdata;
                rsp_err_q   <= axi_rresp[1];
            end else if (wr_fin) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= b_hs ? axi_bresp[1] : b_err_q;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_hs) state_d = icb_cmd_read ? RD : WR;
            RD:      if (r_hs) state_d = FIN;
            WR:      if (wr_fin) state_d = FIN;
            default: if (icb_rsp_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            ar_done <= (state_d == IDLE) ? 1'b0 : ar_done | ar_hs;
            aw_done <= (state_d == IDLE) ? 1'b0 : aw_done | aw_hs;
            w_done  <= (state_d == IDLE) ? 1'b0 : w_done | w_hs;
            if (cmd_hs) begin
                addr_q  <= icb_cmd_addr;
                wdata_q <= icb_cmd_wdata;
                wmask_q <= icb_cmd_wmask;
            end
        end
    end
endmodule

// File: tb/tb_sirv_expl_icb2axi.sv
// tb_sirv_expl_icb2axi: table-driven directed bench for the registered-response bridge with a small AXI slave.
module tb_sirv_expl_icb2axi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icb_cmd_valid = 1'b0, icb_cmd_ready, icb_cmd_read = 1'b0;
    logic [31:0] icb_cmd_addr = '0, icb_cmd_wdata = '0;
    logic [3:0]  icb_cmd_wmask = '0;
    logic        icb_rsp_valid, icb_rsp_ready = 1'b1, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;
    logic        axi_arvalid, axi_arready, axi_awvalid, axi_awready;
    logic [31:0] axi_araddr, axi_awaddr, axi_wdata;
    logic [3:0]  axi_arcache, axi_awcache, axi_arlen, axi_awlen, axi_wstrb;
    logic [2:0]  axi_arprot, axi_awprot, axi_arsize, axi_awsize;
    logic [1:0]  axi_arlock, axi_awlock, axi_arburst, axi_awburst;
    logic        axi_wvalid, axi_wready, axi_wlast;
    logic        axi_rvalid, axi_rready, axi_rlast, axi_bvalid, axi_bready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp, axi_bresp;

    logic        ar_gate = 1'b1, aw_gate = 1'b1;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_resp = '0;

    int passed = 0, total = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic [3:0]  m_arlen, m_wstrb;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_wlast;

    always #5 clk = ~clk;

    sirv_expl_icb2axi dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
        .icb_rsp_err(icb_rsp_err),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot), .axi_arlock(axi_arlock),
        .axi_arburst(axi_arburst), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awlock(axi_awlock),
        .axi_awburst(axi_awburst), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    // slave: R answers in the AR cycle, B answers in the W cycle; gates stall AR/AW
    assign axi_arready = ar_gate;
    assign axi_rvalid  = axi_arvalid & ar_gate;
    assign axi_rdata   = s_rdata;
    assign axi_rresp   = s_resp;
    assign axi_rlast   = 1'b1;
    assign axi_awready = aw_gate;
    assign axi_wready  = 1'b1;
    assign axi_bvalid  = axi_wvalid;
    assign axi_bresp   = s_resp;

    always @(posedge clk) begin
        if (axi_arvalid && axi_arready) begin
            ar_cnt <= ar_cnt + 1;
            m_araddr <= axi_araddr; m_arlen <= axi_arlen; m_arsize <= axi_arsize; m_arburst <= axi_arburst;
        end
        if (axi_awvalid && axi_awready) begin
            aw_cnt <= aw_cnt + 1;
            m_awaddr <= axi_awaddr;
        end
        if (axi_wvalid && axi_wready) begin
            w_cnt <= w_cnt + 1;
            m_wdata <= axi_wdata; m_wstrb <= axi_wstrb; m_wlast <= axi_wlast;
        end
        if (axi_bvalid && axi_bready) b_cnt <= b_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        int          stall;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic run(input vec_t v);
        int n = 0;
        int ar0 = ar_cnt, aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt;
        logic got = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_read = v.rd; icb_cmd_addr = v.addr;
        icb_cmd_wdata = v.wdata; icb_cmd_wmask = v.wmask;
        s_rdata = v.sdata; s_resp = v.sresp;
        ar_gate = (v.stall == 0); aw_gate = (v.stall == 0);
        icb_rsp_ready = (v.hold == 0);
        chk("cmd_ready_idle", {63'd0, icb_cmd_ready}, 64'd1);
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        while (!got && n < 20) begin
            if (n == v.stall) begin ar_gate = 1'b1; aw_gate = 1'b1; end
            @(posedge clk); #1;
            n++;
            got = icb_rsp_valid;
        end
        chk("rsp_timeout", {63'd0, got}, 64'd1);
        chk("rsp_latency", 64'(n), 64'(v.exp_done));
        chk("rsp_rdata", {32'd0, icb_rsp_rdata}, {32'd0, v.exp_rdata});
        chk("rsp_err", {63'd0, icb_rsp_err}, {63'd0, v.exp_err});
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            chk("rsp_hold", {27'd0, icb_rsp_valid, icb_cmd_ready, axi_arvalid, axi_awvalid, icb_rsp_err, icb_rsp_rdata},
                {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, v.exp_err, v.exp_rdata});
        end
        icb_rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("back_idle", {62'd0, icb_cmd_ready, icb_rsp_valid}, 64'd2);
        if (v.rd) begin
            chk("ar_beats", 64'(ar_cnt - ar0), 64'd1);
            chk("ar_fields", {21'd0, m_araddr, m_arlen, m_arsize, m_arburst}, {21'd0, v.addr, 4'd0, 3'd2, 2'b01});
        end else begin
            chk("aw_w_b_beats", {32'(aw_cnt - aw0), 32'(w_cnt - w0)}, {32'd1, 32'd1});
            chk("b_beats", 64'(b_cnt - b0), 64'd1);
            chk("aw_w_fields", {27'd0, m_awaddr, m_wlast, m_wstrb}, {27'd0, v.addr, 1'b1, v.wmask});
            chk("w_data", {32'd0, m_wdata}, {32'd0, v.wdata});
        end
    endtask

    initial begin
        //           rd    addr           wdata          mask   sdata          resp   st hd exp_rdata      err  done
        vecs[0] = '{1'b1, 32'h1000_0010, 32'h0,         4'h0, 32'h0,         2'b00, 0, 0, 32'h0,         1'b0, 1};
        vecs[1] = '{1'b0, 32'h1000_0020, 32'hA5A5_5A5A, 4'hF, 32'h1234_5678, 2'b00, 0, 0, 32'h0,         1'b0, 1};
        vecs[2] = '{1'b0, 32'h1000_0030, 32'h1122_3344, 4'h5, 32'h0,         2'b00, 5, 0, 32'h0,         1'b0, 6};
        vecs[3] = '{1'b1, 32'h1000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b10, 0, 4, 32'hDEAD_BEEF, 1'b1, 1};
        vecs[4] = '{1'b1, 32'h1000_0044, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b01, 3, 0, 32'hCAFE_F00D, 1'b0, 4};
        vecs[5] = '{1'b0, 32'h1000_004C, 32'h0BAD_F00D, 4'h3, 32'hFFFF_FFFF, 2'b11, 0, 2, 32'h0,         1'b1, 1};
        vecs[6] = '{1'b0, 32'h1000_0050, 32'h7777_8888, 4'hC, 32'h0,         2'b10, 2, 0, 32'h0,         1'b1, 3};
        #1;
        chk("reset_state", {55'd0, icb_cmd_ready, icb_rsp_valid, icb_rsp_err, axi_arvalid, axi_awvalid,
                            axi_wvalid, axi_rready, axi_bready}, {55'd0, 8'b1000_0000});
        chk("reset_rdata", {32'd0, icb_rsp_rdata}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) run(vecs[i]);

        // abandon a write stuck on AW by asynchronous reset, then a read must still work
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = 32'h1000_0060;
        icb_cmd_wdata = 32'h5555_AAAA; icb_cmd_wmask = 4'hF; aw_gate = 1'b0;
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("wr_awvalid_stuck", {62'd0, axi_awvalid, icb_cmd_ready}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_drop", {57'd0, axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready,
                                 icb_rsp_valid, icb_cmd_ready}, 64'd1);
        aw_gate = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run(vecs[3]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
